// File: rtl/fiber_bank_arbiter.sv
// fiber_bank_arbiter: round-robin front end multiplexing NUM_PE request channels onto one fiberBank
// request port, with an in-order owner FIFO that steers bank read responses back to the issuing PE.
module fiber_bank_arbiter #(
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned OWN_DEPTH  = 8
) (
  input  logic                             i_clk,
  input  logic                             i_nreset,
  input  logic [NUM_PE*4-1:0]              i_pe_request_type,
  input  logic [NUM_PE*ADDR_WIDTH-1:0]     i_pe_addr,
  input  logic [NUM_PE*DATA_WIDTH-1:0]     i_pe_data,
  input  logic [NUM_PE-1:0]                i_pe_type_valid,
  output logic [NUM_PE-1:0]                o_pe_type_ready,
  output logic [DATA_WIDTH-1:0]            o_pe_data_o,
  output logic [NUM_PE-1:0]                o_pe_data_o_valid,
  input  logic [NUM_PE-1:0]                i_pe_data_o_ready,
  output logic [3:0]                       o_bank_request_type,
  output logic [ADDR_WIDTH-1:0]            o_bank_addr,
  output logic [DATA_WIDTH-1:0]            o_bank_data,
  output logic                             o_bank_type_valid,
  input  logic                             i_bank_type_ready,
  input  logic [DATA_WIDTH-1:0]            i_bank_data_o,
  input  logic                             i_bank_data_o_valid,
  output logic                             o_bank_data_o_ready,
  output logic [$clog2(OWN_DEPTH+1)-1:0]   o_outstanding,
  output logic                             o_drop
);

  localparam int unsigned PW = $clog2(NUM_PE);
  localparam int unsigned FW = $clog2(OWN_DEPTH);
  localparam int unsigned CW = $clog2(OWN_DEPTH + 1);

  logic [3:0]            pe_type [NUM_PE];
  logic [ADDR_WIDTH-1:0] pe_addr [NUM_PE];
  logic [DATA_WIDTH-1:0] pe_data [NUM_PE];
  logic [NUM_PE-1:0]     type_ok;
  logic [NUM_PE-1:0]     rd_like;
  logic [NUM_PE-1:0]     eligible;
  logic [NUM_PE-1:0]     malformed;

  logic [PW-1:0] rr_q, rr_d;
  logic          lock_q, lock_d;
  logic [PW-1:0] lock_idx_q, lock_idx_d;

  logic [FW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] own_mem_q [OWN_DEPTH];

  logic          full;
  logic          empty;
  logic [PW-1:0] head;

  logic [PW:0]   scan_sum;
  logic [PW-1:0] scan_idx;
  logic [PW-1:0] cand_idx;
  logic          cand_found;

  logic [PW-1:0] sel_idx;
  logic [PW-1:0] sel_next;
  logic          fwd;
  logic          drop;
  logic          accept;
  logic          push;
  logic          pop;

  assign full  = (count_q == CW'(OWN_DEPTH));
  assign empty = (count_q == '0);
  assign head  = own_mem_q[rd_ptr_q];

  // Per-PE decode: READ/CONSUME are held off while the owner FIFO is full (registered full).
  always_comb begin : pe_decode
    for (int unsigned k = 0; k < NUM_PE; k++) begin
      pe_type[k]   = i_pe_request_type[4*k +: 4];
      pe_addr[k]   = i_pe_addr[ADDR_WIDTH*k +: ADDR_WIDTH];
      pe_data[k]   = i_pe_data[DATA_WIDTH*k +: DATA_WIDTH];
      type_ok[k]   = $onehot(pe_type[k]);
      rd_like[k]   = pe_type[k][1] | pe_type[k][3];
      eligible[k]  = i_pe_type_valid[k] & type_ok[k] & ~(rd_like[k] & full);
      malformed[k] = i_pe_type_valid[k] & ~type_ok[k];
    end
  end

  // First PE at/after the RR pointer that is either grantable or due to be dropped.
  always_comb begin : rr_scan
    cand_found = 1'b0;
    cand_idx   = rr_q;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      scan_sum = {1'b0, rr_q} + (PW+1)'(i);
      if (scan_sum >= (PW+1)'(NUM_PE)) begin
        scan_sum = scan_sum - (PW+1)'(NUM_PE);
      end
      scan_idx = scan_sum[PW-1:0];
      if (!cand_found && (eligible[scan_idx] || malformed[scan_idx])) begin
        cand_found = 1'b1;
        cand_idx   = scan_idx;
      end
    end
  end

  // A stalled grant stays locked to the same PE until the bank accepts it.
  always_comb begin : grant
    sel_idx  = lock_q ? lock_idx_q : cand_idx;
    fwd      = lock_q | (cand_found & eligible[cand_idx]);
    drop     = ~lock_q & cand_found & malformed[cand_idx];
    accept   = fwd & i_bank_type_ready;
    push     = accept & rd_like[sel_idx];
    sel_next = (sel_idx == PW'(NUM_PE - 1)) ? '0 : sel_idx + PW'(1);
  end

  always_comb begin : bank_side
    o_bank_type_valid   = fwd;
    o_bank_request_type = fwd ? pe_type[sel_idx] : '0;
    o_bank_addr         = fwd ? pe_addr[sel_idx] : '0;
    o_bank_data         = fwd ? pe_data[sel_idx] : '0;
    o_drop              = drop;
    o_pe_type_ready     = '0;
    if (accept || drop) begin
      o_pe_type_ready[sel_idx] = 1'b1;
    end
  end

  // Responses go to the FIFO head only; orphan bank data with an empty FIFO is stalled.
  always_comb begin : resp_side
    o_pe_data_o         = i_bank_data_o;
    o_bank_data_o_ready = ~empty & i_pe_data_o_ready[head];
    pop                 = i_bank_data_o_valid & o_bank_data_o_ready;
    o_pe_data_o_valid   = '0;
    for (int unsigned k = 0; k < NUM_PE; k++) begin
      o_pe_data_o_valid[k] = ~empty & i_bank_data_o_valid & (head == PW'(k));
    end
  end

  always_comb begin : next_state
    rr_d       = (accept || drop) ? sel_next : rr_q;
    lock_d     = fwd & ~i_bank_type_ready;
    lock_idx_d = lock_d ? sel_idx : lock_idx_q;
    wr_ptr_d   = push ? wr_ptr_q + FW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + FW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin : state_regs
    if (!i_nreset) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Owner storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge i_clk) begin : owner_mem
    if (push) begin
      own_mem_q[wr_ptr_q] <= sel_idx;
    end
  end

  assign o_outstanding = count_q;

endmodule
